seven_seg_display: RTL



---
 rtl/seven_seg_pkg.sv | 28 ++
 rtl/seven_seg_glyph.sv | 13 +
 rtl/seven_seg_display.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/seven_seg_pkg.sv
// Shared constants, FSM state type and helpers for the seven-segment display driver.
package seven_seg_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_DASH  = 8'hBF;

    // Active-low patterns for nibbles 0..F, entry 0 in the low byte; bit7 (dp) kept off
    localparam logic [15:0][7:0] SEG_GLYPHS = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        UPDATE  = 2'd2
    } state_e;

    function automatic logic [63:0] pow10(input int unsigned n);
        logic [63:0] r;
        r = 64'd1;
        for (int unsigned i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

endpackage

// File: rtl/seven_seg_glyph.sv
// Nibble to active-low a..g segment pattern decoder.
module seven_seg_glyph
    import seven_seg_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] pat_o
);

    always_comb begin
        pat_o = SEG_GLYPHS[nib_i][6:0];
    end

endmodule

// File: rtl/seven_seg_display.sv
// Multi-digit seven-segment driver: hex or double-dabble decimal, registered active-low outputs.
// SEVEN_SEG_LZB_EN enables leading-zero blanking.
module seven_seg_display
    import seven_seg_pkg::*;
#(
    parameter int unsigned DIGITS  = 6,
    parameter int unsigned VALUE_W = 20
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [VALUE_W-1:0]    value,
    input  logic                  hex_mode,
    input  logic [DIGITS-1:0]     dp,
    input  logic                  load,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [8*DIGITS-1:0]   seg
);

    localparam int unsigned HEX_W     = 4 * DIGITS;
    localparam int unsigned CNT_W     = $clog2(VALUE_W + 1);
    localparam logic [63:0] DEC_LIMIT = pow10(DIGITS);

    state_e                state_q, state_d;
    logic [VALUE_W-1:0]    bin_q, bin_d;
    logic [HEX_W-1:0]      bcd_q, bcd_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DIGITS-1:0]     dp_q, dp_d;
    logic                  ovf_q, ovf_d;
    logic [8*DIGITS-1:0]   pat_q, pat_d;
    logic                  commit_q, commit_d;
    logic [8*DIGITS-1:0]   seg_q, seg_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  overflow_q, overflow_d;

    logic [63:0]               value_ext;
    logic                      ovf_c;
    logic [HEX_W-1:0]          bcd_adj;
    logic [DIGITS-1:0]         blank;
    logic [DIGITS-1:0][6:0]    glyph_pat;
    logic [8*DIGITS-1:0]       pat_c;

    assign value_ext = 64'(value);
    assign ovf_c     = hex_mode ? ((value_ext >> HEX_W) != 64'd0) : (value_ext >= DEC_LIMIT);

    // Add-3 correction applied ahead of each double-dabble shift
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    for (genvar g = 0; g < int'(DIGITS); g++) begin : g_glyph
        seven_seg_glyph u_glyph (
            .nib_i (bcd_q[4*g +: 4]),
            .pat_o (glyph_pat[g])
        );
    end

`ifdef SEVEN_SEG_LZB_EN
    // A digit is blank when it and every digit above it are zero; digit 0 always shows
    always_comb begin
        logic zero_above;
        zero_above = 1'b1;
        blank      = '0;
        for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
            zero_above = zero_above && (bcd_q[4*i +: 4] == 4'd0);
            blank[i]   = zero_above;
        end
    end
`else
    assign blank = '0;
`endif

    always_comb begin
        pat_c = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (ovf_q) begin
                pat_c[8*i +: 8] = SEG_DASH;
            end else begin
                pat_c[8*i +: 8] = {~dp_q[i], blank[i] ? SEG_BLANK[6:0] : glyph_pat[i]};
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        dp_d       = dp_q;
        ovf_d      = ovf_q;
        pat_d      = pat_q;
        commit_d   = 1'b0;
        seg_d      = seg_q;
        done_d     = 1'b0;
        overflow_d = overflow_q;

        // Staged pattern reaches the pins together with done
        if (commit_q) begin
            seg_d      = pat_q;
            done_d     = 1'b1;
            overflow_d = ovf_q;
        end

        unique case (state_q)
            IDLE: begin
                if (load && !busy_q) begin
                    bin_d = value;
                    dp_d  = dp;
                    ovf_d = ovf_c;
                    cnt_d = '0;
                    if (hex_mode) begin
                        bcd_d   = HEX_W'(value);
                        state_d = UPDATE;
                    end else begin
                        bcd_d   = '0;
                        state_d = CONVERT;
                    end
                end
            end
            CONVERT: begin
                bcd_d = HEX_W'({bcd_adj, bin_q[VALUE_W-1]});
                bin_d = bin_q << 1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(VALUE_W - 1)) begin
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                pat_d    = pat_c;
                commit_d = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE) || commit_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            bin_q      <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            dp_q       <= '0;
            ovf_q      <= 1'b0;
            pat_q      <= {DIGITS{SEG_BLANK}};
            commit_q   <= 1'b0;
            seg_q      <= {DIGITS{SEG_BLANK}};
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            cnt_q      <= cnt_d;
            dp_q       <= dp_d;
            ovf_q      <= ovf_d;
            pat_q      <= pat_d;
            commit_q   <= commit_d;
            seg_q      <= seg_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
        end
    end

    assign seg      = seg_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign overflow = overflow_q;

endmodule
